// File: rtl/fib_seq_gen.sv
// rtl/fib_seq_gen.sv - generalised Fibonacci term generator with age-indexed history; FIB_SAT_EN selects saturating addition
module fib_seq_gen #(
  parameter  int WIDTH      = 32,
  parameter  int HIST_DEPTH = 8,
  localparam int IDX_W      = $clog2(HIST_DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stb,
  input  logic [WIDTH-1:0] i_n,
  input  logic [WIDTH-1:0] i_seed0,
  input  logic [WIDTH-1:0] i_seed1,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_fib,
  output logic             o_ovf,
  input  logic [IDX_W-1:0] i_hist_idx,
  output logic [WIDTH-1:0] o_hist,
  output logic [IDX_W:0]   o_hist_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IDX_W:0] HIST_FULL = (IDX_W + 1)'(HIST_DEPTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] cnt;
  logic             ovf;
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W:0]   hist_count;
  logic [WIDTH-1:0] hist_mem [HIST_DEPTH];

  logic [WIDTH:0]   sum_full;
  logic             carry;
  logic [WIDTH-1:0] next_b;
  logic [IDX_W-1:0] rd_ptr;

  // Next term: full-width sum so the carry is visible; saturate or wrap on overflow
  always_comb begin
    sum_full = {1'b0, a} + {1'b0, b};
    carry    = sum_full[WIDTH];
`ifdef FIB_SAT_EN
    next_b   = carry ? '1 : sum_full[WIDTH-1:0];
`else
    next_b   = sum_full[WIDTH-1:0];
`endif
  end

  // Control FSM and iteration registers (a = F(k), b = F(k+1), cnt = steps left)
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= S_IDLE;
      a          <= '0;
      b          <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      wr_ptr     <= '0;
      hist_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_stb) begin
            a          <= i_seed0;
            b          <= i_seed1;
            cnt        <= i_n;
            ovf        <= 1'b0;
            wr_ptr     <= '0;
            hist_count <= '0;
            state      <= (i_n != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          a      <= b;
          b      <= next_b;
          cnt    <= cnt - WIDTH'(1);
          wr_ptr <= wr_ptr + IDX_W'(1);
          if (carry) begin
            ovf <= 1'b1;
          end
          if (hist_count != HIST_FULL) begin
            hist_count <= hist_count + (IDX_W + 1)'(1);
          end
          if (cnt == WIDTH'(1)) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // History ring: each RUN step records the term that becomes the new a
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_mem[i] <= '0;
      end
    end else if (state == S_RUN) begin
      hist_mem[wr_ptr] <= b;
    end
  end

  // Age-indexed read: newest entry sits one slot behind the write pointer
  always_comb begin
    rd_ptr = wr_ptr - IDX_W'(1) - i_hist_idx;
    if ({1'b0, i_hist_idx} < hist_count) begin
      o_hist = hist_mem[rd_ptr];
    end else begin
      o_hist = '0;
    end
  end

  assign o_busy       = (state == S_RUN);
  assign o_done       = (state == S_DONE);
  assign o_fib        = a;
  assign o_ovf        = ovf;
  assign o_hist_count = hist_count;

endmodule

// File: tb/tb_fib_seq_gen.sv
// tb/tb_fib_seq_gen.sv - self-checking bench for fib_seq_gen (wide/deep and narrow/shallow instances)
module tb_fib_seq_gen;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        stb;
  logic [31:0] n_in, s0_in, s1_in;
  logic [2:0]  idx;

  logic        busy_a, done_a, ovf_a;
  logic [31:0] fib_a, hist_a;
  logic [3:0]  cnt_a;
  logic        busy_b, done_b, ovf_b;
  logic [7:0]  fib_b, hist_b;
  logic [2:0]  cnt_b;

  fib_seq_gen #(.WIDTH(32), .HIST_DEPTH(8)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_stb(stb & ~sel), .i_n(n_in),
    .i_seed0(s0_in), .i_seed1(s1_in), .o_busy(busy_a), .o_done(done_a),
    .o_fib(fib_a), .o_ovf(ovf_a), .i_hist_idx(idx), .o_hist(hist_a),
    .o_hist_count(cnt_a)
  );

  fib_seq_gen #(.WIDTH(8), .HIST_DEPTH(4)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_stb(stb & sel), .i_n(n_in[7:0]),
    .i_seed0(s0_in[7:0]), .i_seed1(s1_in[7:0]), .o_busy(busy_b), .o_done(done_b),
    .o_fib(fib_b), .o_ovf(ovf_b), .i_hist_idx(idx[1:0]), .o_hist(hist_b),
    .o_hist_count(cnt_b)
  );

  logic        busy, done, ovf;
  logic [31:0] fib, hist, hcnt;

  always_comb begin
    busy = sel ? busy_b : busy_a;
    done = sel ? done_b : done_a;
    ovf  = sel ? ovf_b : ovf_a;
    fib  = sel ? {24'b0, fib_b} : fib_a;
    hist = sel ? {24'b0, hist_b} : hist_a;
    hcnt = sel ? {29'b0, cnt_b} : {28'b0, cnt_a};
  end

  int vectors = 0;
  int errs    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: build the term list F(0)..F(n+1) with plain arithmetic.
  // Each run step produces one new term, so n steps generate F(2)..F(n+1).
  logic [63:0] exp_fib, exp_ovf, exp_cnt;
  logic [63:0] exp_h [8];

  task automatic model(input int w, input int d, input int n,
                       input logic [31:0] sd0, input logic [31:0] sd1);
    logic [63:0] f[$];
    logic [63:0] mask, s;
    mask = (w == 32) ? 64'hFFFF_FFFF : 64'hFF;
    f.push_back(64'(sd0) & mask);
    f.push_back(64'(sd1) & mask);
    exp_ovf = 0;
    for (int k = 2; k <= n + 1; k++) begin
      s = f[k-1] + f[k-2];
      if (s > mask) begin
        exp_ovf = 1;
`ifdef FIB_SAT_EN
        s = mask;
`else
        s = s & mask;
`endif
      end
      f.push_back(s);
    end
    exp_fib = f[n];
    exp_cnt = (n < d) ? 64'(n) : 64'(d);
    for (int i = 0; i < 8; i++) begin
      exp_h[i] = (i < exp_cnt) ? f[n-i] : 64'd0;
    end
  endtask

  // One complete run, optionally pulsing a competing start at RUN cycle glitch_at
  task automatic run(input bit s, input int n, input logic [31:0] sd0,
                     input logic [31:0] sd1, input int glitch_at);
    int d, lat, busyc;
    d = s ? 4 : 8;
    sel = s;
    model(s ? 8 : 32, d, n, sd0, sd1);
    stb = 1'b1; n_in = n; s0_in = sd0; s1_in = sd1;
    tick();
    stb = 1'b0; n_in = $urandom; s0_in = $urandom; s1_in = $urandom;
    lat = 1; busyc = 0;
    while (!done && lat < n + 5) begin
      if (busy) busyc++;
      if (lat == glitch_at) begin
        stb = 1'b1; n_in = 3;
      end else begin
        stb = 1'b0;
      end
      tick();
      lat++;
    end
    stb = 1'b0;
    chk("done_seen", done, 1);
    chk("latency", lat, n + 1);
    chk("busy_cycles", busyc, n);
    chk("busy_at_done", busy, 0);
    chk("fib", fib, exp_fib);
    chk("ovf", ovf, exp_ovf);
    chk("hist_count", hcnt, exp_cnt);
    for (int i = 0; i < d; i++) begin
      idx = 3'(i);
      #1;
      chk($sformatf("hist[%0d]", i), hist, exp_h[i]);
    end
    stb = 1'b1; n_in = 5;
    tick();
    stb = 1'b0;
    chk("done_pulse_width", done, 0);
    chk("stb_in_done_ignored", busy, 0);
    chk("fib_hold", fib, exp_fib);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; sel = 1'b0; stb = 1'b0; n_in = 0; s0_in = 0; s1_in = 0; idx = 0;
    tick(); tick();

    // Reset state of both instances
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_fib", fib, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_hist_count", hcnt, 0);
      chk("rst_hist0", hist, 0);
    end
    rst = 1'b0;
    tick();

    // Directed scenarios
    run(0, 10, 0, 1, -1);
    chk("std_n10_fib", fib, 55);
    run(0, 5, 2, 1, -1);
    chk("lucas_n5_fib", fib, 11);
    run(0, 0, 9, 4, -1);
    chk("zero_n_fib", fib, 9);
    run(1, 14, 0, 1, -1);
`ifdef FIB_SAT_EN
    chk("ovf8_fib", fib, 255);
`else
    chk("ovf8_fib", fib, 121);
`endif
    chk("ovf8_flag", ovf, 1);
    run(1, 10, 0, 1, -1);
    chk("wrap4_count", hcnt, 4);
    run(0, 10, 0, 1, 2);
    chk("stb_in_run_fib", fib, 55);

    // Reset in the middle of a run
    sel = 1'b0;
    stb = 1'b1; n_in = 10; s0_in = 0; s1_in = 1;
    tick();
    stb = 1'b0;
    tick(); tick(); tick();
    chk("busy_before_reset", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_fib", fib, 0);
    chk("abort_hist_count", hcnt, 0);
    chk("abort_done", done, 0);
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("no_done_after_abort", seen, 0);
    run(0, 10, 0, 1, -1);
    chk("restart_fib", fib, 55);

    // Randomised runs on both instances
    for (int i = 0; i < 12; i++) begin
      run(0, int'($urandom_range(0, 40)), $urandom, $urandom, -1);
      run(1, int'($urandom_range(0, 20)), $urandom_range(0, 40), $urandom_range(0, 40), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/fib_seq_gen.md
Name: fib_seq_gen

Overview:
- Parametrised successor to the team's Fibonacci iterator.
- Computes term n of a generalised Fibonacci recurrence: F(0)=seed0, F(1)=seed1, F(k)=F(k-1)+F(k-2), with user-supplied seeds.
- Keeps a circular history of the most recent HIST_DEPTH terms, readable by age, and flags arithmetic overflow.
- Used as a self-checking arithmetic test block on the design's clock/reset domain.

Parameters:
- WIDTH, 32, datapath width of terms, seeds and n.
- HIST_DEPTH, 8, history entries; power of two, >= 2.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_stb  in  1  start request; sampled only when idle.
- i_n  in  WIDTH  index of the term to compute; captured on an accepted i_stb.
- i_seed0  in  WIDTH  F(0); captured on an accepted i_stb.
- i_seed1  in  WIDTH  F(1); captured on an accepted i_stb.
- o_busy  out  1  high while iterating.
- o_done  out  1  one-cycle pulse when o_fib holds F(n).
- o_fib  out  WIDTH  current term F(k); holds F(n) after o_done.
- o_ovf  out  1  sticky carry-out flag for the current run.
- i_hist_idx  in  clog2(HIST_DEPTH)  age index; 0 = most recent term.
- o_hist  out  WIDTH  history entry at i_hist_idx; combinational read.
- o_hist_count  out  clog2(HIST_DEPTH)+1  valid entries, saturates at HIST_DEPTH.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; all registers, history entries, o_hist_count and o_ovf cleared.
  - o_busy=0, o_done=0, o_fib=0.
  - Reset during RUN aborts the run; no o_done is produced.
- State encoding: IDLE, RUN, DONE.
- Internal registers: a=F(k), b=F(k+1), cnt = remaining steps. o_fib = a.
- IDLE with i_stb=1 (start accepted):
  - a<=i_seed0, b<=i_seed1, cnt<=i_n.
  - o_ovf<=0, o_hist_count<=0, write pointer reset to 0.
  - Next state is RUN if i_n!=0, otherwise DONE.
- RUN, each cycle:
  - a<=b, b<=a+b (mod 2^WIDTH), cnt<=cnt-1.
  - Push the new a (old b) into the history at the write pointer; pointer wraps modulo HIST_DEPTH.
  - o_hist_count increments, saturating at HIST_DEPTH.
  - A carry out of a+b sets o_ovf; it stays set until the next accepted start.
  - When cnt==1, next state is DONE.
- DONE: o_done=1 for exactly one cycle, then IDLE. In this cycle o_fib=F(n) and o_busy=0.
- o_busy = (state==RUN).
- Latency: i_stb accepted in cycle t -> o_busy high for cycles t+1..t+n -> o_done in cycle t+n+1.
  - For n=0: no busy cycles; o_done in cycle t+1 with o_fib=seed0.
- i_stb while in RUN or DONE is ignored; no queuing.
- o_fib and the history hold their values after DONE until the next accepted start or reset.
- History read:
  - o_hist = entry written (i_hist_idx+1) pushes ago.
  - Reads 0 when i_hist_idx >= o_hist_count.
  - After a run with n >= HIST_DEPTH, index 0 reads F(n) and index HIST_DEPTH-1 reads F(n-HIST_DEPTH+1).
- Large n is permitted: cnt is WIDTH bits, so up to 2^WIDTH-1 cycles.

Optional Feature:
- Macro: FIB_SAT_EN.
- Defined: addition saturates.
  - On carry out, b<=all-ones and o_ovf sets.
  - Subsequent sums involving all-ones also saturate, so terms stay at 2^WIDTH-1.
- Undefined: addition wraps modulo 2^WIDTH; o_ovf still reports the carry.

Test Plan:
- Standard seeds, n=10: seeds 0/1, HIST_DEPTH=8, i_n=10 -> o_busy for 10 cycles; o_done at t+11 with o_fib=55, o_ovf=0; o_hist idx0..3 = 55,34,21,13; o_hist_count=8.
- Lucas seeds, n=5: seeds 2/1, i_n=5 -> o_fib=11 at o_done; idx0..4 = 11,7,4,3,1; o_hist_count=5; idx5 reads 0.
- Zero index: seeds 9/4, i_n=0 -> o_busy never high; o_done at t+1; o_fib=9; o_hist_count=0.
- Overflow: WIDTH=8, seeds 0/1, i_n=14 -> wrap build: o_fib=121, o_ovf=1. With FIB_SAT_EN: o_fib=255, o_ovf=1.
- History wrap: HIST_DEPTH=4, seeds 0/1, i_n=10 -> idx0..3 = 55,34,21,13; o_hist_count=4.
- Control hazards:
  - i_stb with i_n=3 pulsed at RUN cycle 2 of an n=10 run -> ignored; result still 55.
  - i_reset asserted at RUN cycle 4 -> next cycle o_busy=0, o_fib=0, o_hist_count=0, no o_done.
  - A new start after the reset runs normally.
